// File: rtl/uart_dma_engine.sv
// Two-channel byte DMA between memory and the UART data registers, sharing one
// AXI4-Lite master with a single transaction in flight.
module uart_dma_engine #(
  parameter logic [31:0] UART_BASE  = 32'h0000_0000,
  parameter logic [31:0] TXDATA_OFS = 32'h0,
  parameter logic [31:0] RXDATA_OFS = 32'h4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [31:0] tx_addr,
  input  logic [15:0] tx_len,
  input  logic        rx_start,
  input  logic [31:0] rx_addr,
  input  logic [15:0] rx_len,
  output logic        tx_busy,
  output logic        rx_busy,
  output logic        tx_done,
  output logic        rx_done,
  output logic        tx_err,
  output logic        rx_err,
  input  logic        dma_tx_req,
  input  logic        dma_rx_req,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);
  // state | meaning
  // IDLE  | no channel busy
  // ARB   | sample requests, RX wins over TX
  // RD_A  | read address phase
  // RD_D  | read data phase, capture byte
  // WR    | AW and W outstanding, each drops on its own ready
  // WR_B  | wait for write response
  // UPD   | advance address/count, done on last byte
  typedef enum logic [2:0] {S_IDLE, S_ARB, S_RD_A, S_RD_D, S_WR, S_WR_B, S_UPD} state_t;
  localparam logic CH_TX = 1'b0;
  localparam logic CH_RX = 1'b1;

  state_t      state_q, state_d;
  logic        ch_q, ch_d;
  logic [7:0]  byte_q, byte_d;
  logic        aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
  logic [31:0] tx_addr_q, tx_addr_d, rx_addr_q, rx_addr_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic        tx_busy_q, tx_busy_d, rx_busy_q, rx_busy_d;
  logic        tx_err_q, tx_err_d, rx_err_q, rx_err_d;
  logic        tx_zdone_q, tx_zdone_d, rx_zdone_q, rx_zdone_d;
  logic        abort;
  logic        last_upd;

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    byte_d     = byte_q;
    aw_pend_d  = aw_pend_q;
    w_pend_d   = w_pend_q;
    tx_addr_d  = tx_addr_q;
    rx_addr_d  = rx_addr_q;
    tx_cnt_d   = tx_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    tx_busy_d  = tx_busy_q;
    rx_busy_d  = rx_busy_q;
    tx_err_d   = tx_err_q;
    rx_err_d   = rx_err_q;
    tx_zdone_d = 1'b0;
    rx_zdone_d = 1'b0;
    abort      = 1'b0;

    if (tx_start && !tx_busy_q) begin
      tx_err_d = 1'b0;
      if (tx_len == 16'd0) tx_zdone_d = 1'b1;
      else begin
        tx_busy_d = 1'b1;
        tx_addr_d = tx_addr;
        tx_cnt_d  = tx_len;
      end
    end
    if (rx_start && !rx_busy_q) begin
      rx_err_d = 1'b0;
      if (rx_len == 16'd0) rx_zdone_d = 1'b1;
      else begin
        rx_busy_d = 1'b1;
        rx_addr_d = rx_addr;
        rx_cnt_d  = rx_len;
      end
    end

    unique case (state_q)
      S_IDLE: if (tx_busy_d || rx_busy_d) state_d = S_ARB;
      S_ARB: begin
        if (rx_busy_q && dma_rx_req) begin
          ch_d    = CH_RX;
          state_d = S_RD_A;
        end else if (tx_busy_q && dma_tx_req) begin
          ch_d    = CH_TX;
          state_d = S_RD_A;
        end else if (!tx_busy_d && !rx_busy_d) begin
          state_d = S_IDLE;
        end
      end
      S_RD_A: if (m_axi_arready) state_d = S_RD_D;
      S_RD_D: begin
        if (m_axi_rvalid) begin
          byte_d = (ch_q == CH_RX) ? m_axi_rdata[7:0]
                                   : m_axi_rdata[{tx_addr_q[1:0], 3'b000} +: 8];
          if (m_axi_rresp != 2'b00) abort = 1'b1;
          else begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = S_WR;
          end
        end
      end
      S_WR: begin
        if (m_axi_awready) aw_pend_d = 1'b0;
        if (m_axi_wready) w_pend_d = 1'b0;
        if (!aw_pend_d && !w_pend_d) state_d = S_WR_B;
      end
      S_WR_B: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) abort = 1'b1;
          else state_d = S_UPD;
        end
      end
      S_UPD: begin
        if (ch_q == CH_RX) begin
          rx_addr_d = rx_addr_q + 32'd1;
          rx_cnt_d  = rx_cnt_q - 16'd1;
          if (rx_cnt_q == 16'd1) rx_busy_d = 1'b0;
        end else begin
          tx_addr_d = tx_addr_q + 32'd1;
          tx_cnt_d  = tx_cnt_q - 16'd1;
          if (tx_cnt_q == 16'd1) tx_busy_d = 1'b0;
        end
        state_d = S_ARB;
      end
      default: state_d = S_IDLE;
    endcase

    // a bus error ends the transfer silently; err stays until the next start
    if (abort) begin
      state_d = S_IDLE;
      if (ch_q == CH_RX) begin
        rx_err_d  = 1'b1;
        rx_busy_d = 1'b0;
      end else begin
        tx_err_d  = 1'b1;
        tx_busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ch_q       <= CH_TX;
      byte_q     <= 8'h0;
      aw_pend_q  <= 1'b0;
      w_pend_q   <= 1'b0;
      tx_addr_q  <= 32'h0;
      rx_addr_q  <= 32'h0;
      tx_cnt_q   <= 16'h0;
      rx_cnt_q   <= 16'h0;
      tx_busy_q  <= 1'b0;
      rx_busy_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      rx_err_q   <= 1'b0;
      tx_zdone_q <= 1'b0;
      rx_zdone_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      byte_q     <= byte_d;
      aw_pend_q  <= aw_pend_d;
      w_pend_q   <= w_pend_d;
      tx_addr_q  <= tx_addr_d;
      rx_addr_q  <= rx_addr_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_busy_q  <= tx_busy_d;
      rx_busy_q  <= rx_busy_d;
      tx_err_q   <= tx_err_d;
      rx_err_q   <= rx_err_d;
      tx_zdone_q <= tx_zdone_d;
      rx_zdone_q <= rx_zdone_d;
    end
  end

  assign last_upd = (state_q == S_UPD) &&
                    (((ch_q == CH_RX) ? rx_cnt_q : tx_cnt_q) == 16'd1);

  assign tx_busy = tx_busy_q;
  assign rx_busy = rx_busy_q;
  assign tx_err  = tx_err_q;
  assign rx_err  = rx_err_q;
  assign tx_done = tx_zdone_q | (last_upd && (ch_q == CH_TX));
  assign rx_done = rx_zdone_q | (last_upd && (ch_q == CH_RX));

  assign m_axi_arprot  = 3'b000;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arvalid = (state_q == S_RD_A);
  assign m_axi_rready  = (state_q == S_RD_D);
  assign m_axi_bready  = (state_q == S_WR_B);
  assign m_axi_awvalid = aw_pend_q;
  assign m_axi_wvalid  = w_pend_q;

  // payloads held for the whole phase so they stay stable under stalls
  assign m_axi_araddr = (state_q != S_RD_A) ? 32'h0 :
                        (ch_q == CH_RX) ? (UART_BASE + RXDATA_OFS) : tx_addr_q;
  assign m_axi_awaddr = (state_q != S_WR) ? 32'h0 :
                        (ch_q == CH_RX) ? rx_addr_q : (UART_BASE + TXDATA_OFS);
  assign m_axi_wdata  = (state_q != S_WR) ? 32'h0 :
                        (ch_q == CH_RX) ? {4{byte_q}} : {24'h0, byte_q};
  assign m_axi_wstrb  = (state_q != S_WR) ? 4'h0 :
                        (ch_q == CH_RX) ? (4'b0001 << rx_addr_q[1:0]) : 4'b0001;
endmodule

// File: tb/tb_uart_dma_engine.sv
// Directed bench for uart_dma_engine: behavioural AXI4-Lite slave with memory,
// UART RXDATA source, optional back-pressure and error injection.
module tb_uart_dma_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_start = 0, rx_start = 0;
  logic [31:0] tx_addr = 0, rx_addr = 0;
  logic [15:0] tx_len = 0, rx_len = 0;
  logic        tx_busy, rx_busy, tx_done, rx_done, tx_err, rx_err;
  logic        dma_tx_req = 0, dma_rx_req = 0;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awready = 0, m_axi_wready = 0, m_axi_bvalid = 0;
  logic        m_axi_arready = 0, m_axi_rvalid = 0;
  logic [1:0]  m_axi_bresp = 0, m_axi_rresp = 0;
  logic [31:0] m_axi_rdata = 0;

  always #5 clk = ~clk;

  uart_dma_engine dut (
    .clk(clk), .rst(rst),
    .tx_start(tx_start), .tx_addr(tx_addr), .tx_len(tx_len),
    .rx_start(rx_start), .rx_addr(rx_addr), .rx_len(rx_len),
    .tx_busy(tx_busy), .rx_busy(rx_busy), .tx_done(tx_done), .rx_done(rx_done),
    .tx_err(tx_err), .rx_err(rx_err),
    .dma_tx_req(dma_tx_req), .dma_rx_req(dma_rx_req),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // slave model state
  logic        bp = 0, hold_w = 0;
  int          err_at = -1, rd_cnt = 0, rx_idx = 0, stab_viol = 0;
  int          tx_busy_cyc = 0, tx_done_cnt = 0, rx_done_cnt = 0;
  logic [31:0] rx_src[$];
  logic [31:0] wq_addr[$], wq_data[$], rd_log[$];
  logic [3:0]  wq_strb[$];
  logic        ar_hs = 0, aw_hs = 0, w_hs = 0, r_hs = 0, b_hs = 0;
  logic        rd_pend = 0, aw_got = 0, w_got = 0;
  logic [31:0] cap_araddr = 0, cap_awaddr = 0, cap_wdata = 0;
  logic [3:0]  cap_wstrb = 0;
  logic        prev_arv = 0, prev_awv = 0, prev_wv = 0;
  logic [31:0] prev_araddr = 0, prev_awaddr = 0, prev_wdata = 0;
  logic [3:0]  prev_wstrb = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case ({a[31:2], 2'b00})
      32'h1000: return 32'hDDCCBBAA;
      32'h1004: return 32'h1122_3344;
      default:  return 32'h0;
    endcase
  endfunction

  function automatic logic rnd_ok();
    return !bp || ($urandom_range(0, 2) == 0);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_axi_arready = 0; m_axi_awready = 0; m_axi_wready = 0;
      m_axi_rvalid = 0; m_axi_bvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_bresp = 0;
      ar_hs = 0; aw_hs = 0; w_hs = 0; r_hs = 0; b_hs = 0;
      rd_pend = 0; aw_got = 0; w_got = 0;
      prev_arv = 0; prev_awv = 0; prev_wv = 0;
    end else begin
      // a valid not taken at the last edge must persist with the same payload
      if (prev_arv && !ar_hs && (!m_axi_arvalid || m_axi_araddr != prev_araddr)) stab_viol++;
      if (prev_awv && !aw_hs && (!m_axi_awvalid || m_axi_awaddr != prev_awaddr)) stab_viol++;
      if (prev_wv && !w_hs && (!m_axi_wvalid || m_axi_wdata != prev_wdata ||
                               m_axi_wstrb != prev_wstrb)) stab_viol++;
      if (ar_hs) rd_pend = 1;
      if (r_hs)  m_axi_rvalid = 0;
      if (aw_hs) aw_got = 1;
      if (w_hs)  w_got = 1;
      if (b_hs)  m_axi_bvalid = 0;
      if (aw_got && w_got && !m_axi_bvalid && rnd_ok()) begin
        wq_addr.push_back(cap_awaddr);
        wq_data.push_back(cap_wdata);
        wq_strb.push_back(cap_wstrb);
        m_axi_bvalid = 1; m_axi_bresp = 2'b00;
        aw_got = 0; w_got = 0;
      end
      if (rd_pend && !m_axi_rvalid && rnd_ok()) begin
        rd_log.push_back(cap_araddr);
        if (cap_araddr == 32'h4) begin
          if (rx_idx < rx_src.size()) m_axi_rdata = rx_src[rx_idx];
          else m_axi_rdata = 32'h0;
          rx_idx++;
        end else m_axi_rdata = mem_word(cap_araddr);
        m_axi_rresp = (rd_cnt == err_at) ? 2'b10 : 2'b00;
        rd_cnt++;
        m_axi_rvalid = 1; rd_pend = 0;
      end
      m_axi_arready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      m_axi_awready = hold_w ? 1'b0 : bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      m_axi_wready  = hold_w ? 1'b0 : bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      ar_hs = m_axi_arvalid && m_axi_arready;
      aw_hs = m_axi_awvalid && m_axi_awready;
      w_hs  = m_axi_wvalid && m_axi_wready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      b_hs  = m_axi_bvalid && m_axi_bready;
      if (ar_hs) cap_araddr = m_axi_araddr;
      if (aw_hs) cap_awaddr = m_axi_awaddr;
      if (w_hs) begin cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb; end
      prev_arv = m_axi_arvalid; prev_araddr = m_axi_araddr;
      prev_awv = m_axi_awvalid; prev_awaddr = m_axi_awaddr;
      prev_wv  = m_axi_wvalid;  prev_wdata  = m_axi_wdata; prev_wstrb = m_axi_wstrb;
    end
    if (tx_busy) tx_busy_cyc++;
    if (tx_done) tx_done_cnt++;
    if (rx_done) rx_done_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_tx(input logic [31:0] a, input logic [15:0] n);
    tx_addr = a; tx_len = n; tx_start = 1; tick(); tx_start = 0;
  endtask

  task automatic start_rx(input logic [31:0] a, input logic [15:0] n);
    rx_addr = a; rx_len = n; rx_start = 1; tick(); rx_start = 0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while ((tx_busy || rx_busy) && n < limit) begin tick(); n++; end
    chk(tag, {31'h0, tx_busy || rx_busy}, 32'h0);
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [31:0] ea,
                        input logic [31:0] ed, input logic [3:0] es);
    logic [31:0] a, d;
    logic [3:0]  s;
    a = 'x; d = 'x; s = 'x;
    if (idx < wq_addr.size()) begin a = wq_addr[idx]; d = wq_data[idx]; s = wq_strb[idx]; end
    chk({tag, "_addr"}, a, ea);
    chk({tag, "_data"}, d, ed);
    chk({tag, "_strb"}, {28'h0, s}, {28'h0, es});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, rb, bc, dc, n;
    repeat (3) tick();
    chk("rst_busy", {30'h0, tx_busy, rx_busy}, 32'h0);
    chk("rst_done_err", {28'h0, tx_done, rx_done, tx_err, rx_err}, 32'h0);
    chk("rst_valids", {27'h0, m_axi_arvalid, m_axi_rready, m_axi_awvalid,
                       m_axi_wvalid, m_axi_bready}, 32'h0);
    chk("rst_awaddr", m_axi_awaddr, 32'h0);
    chk("rst_araddr", m_axi_araddr, 32'h0);
    chk("rst_wdata", m_axi_wdata, 32'h0);
    rst = 0;
    tick();

    // TX 3 bytes from 0x1002, zero-wait
    dma_tx_req = 1;
    b = wq_addr.size(); bc = tx_busy_cyc; dc = tx_done_cnt;
    start_tx(32'h1002, 16'd3);
    chk("tx3_busy_n1", {31'h0, tx_busy}, 32'h1);
    wait_idle("tx3_timeout", 100);
    chk("tx3_nwr", wq_addr.size() - b, 3);
    chk_wr("tx3_b0", b,     32'h0, 32'hCC, 4'b0001);
    chk_wr("tx3_b1", b + 1, 32'h0, 32'hDD, 4'b0001);
    chk_wr("tx3_b2", b + 2, 32'h0, 32'h44, 4'b0001);
    chk("tx3_busy_cycles", tx_busy_cyc - bc, 18);
    chk("tx3_done_cnt", tx_done_cnt - dc, 1);

    // RX 2 bytes to 0x2003
    dma_tx_req = 0; dma_rx_req = 1;
    rx_src.push_back(32'hFFFF_FF5A); rx_src.push_back(32'h1234_56A5);
    b = wq_addr.size(); rb = rd_log.size(); dc = rx_done_cnt;
    start_rx(32'h2003, 16'd2);
    wait_idle("rx2_timeout", 100);
    chk_wr("rx2_b0", b,     32'h2003, 32'h5A5A5A5A, 4'b1000);
    chk_wr("rx2_b1", b + 1, 32'h2004, 32'hA5A5A5A5, 4'b0001);
    chk("rx2_araddr", (rb < rd_log.size()) ? rd_log[rb] : 32'hFFFF_FFFF, 32'h4);
    chk("rx2_done_cnt", rx_done_cnt - dc, 1);

    // both channels busy: stall without requests, RX first, TX while RX req low
    dma_tx_req = 0; dma_rx_req = 0;
    rx_src.push_back(32'h11); rx_src.push_back(32'h22);
    b = wq_addr.size();
    tx_addr = 32'h1000; tx_len = 16'd2; rx_addr = 32'h3000; rx_len = 16'd2;
    tx_start = 1; rx_start = 1; tick(); tx_start = 0; rx_start = 0;
    repeat (20) tick();
    chk("prio_stall_nwr", wq_addr.size() - b, 0);
    chk("prio_both_busy", {30'h0, tx_busy, rx_busy}, 32'h3);
    dma_tx_req = 1; dma_rx_req = 1;
    n = 0;
    while (wq_addr.size() == b && n < 50) begin tick(); n++; end
    dma_rx_req = 0;
    n = 0;
    while (tx_busy && n < 100) begin tick(); n++; end
    chk("prio_tx_finished", {31'h0, tx_busy}, 32'h0);
    chk("prio_rx_still_busy", {31'h0, rx_busy}, 32'h1);
    chk_wr("prio_w0", b,     32'h3000, 32'h11111111, 4'b0001);
    chk_wr("prio_w1", b + 1, 32'h0,    32'hAA,       4'b0001);
    chk_wr("prio_w2", b + 2, 32'h0,    32'hBB,       4'b0001);
    dma_rx_req = 1;
    wait_idle("prio_timeout", 100);
    chk_wr("prio_w3", b + 3, 32'h3001, 32'h22222222, 4'b0010);

    // read error on second TX byte
    dma_rx_req = 0; dma_tx_req = 1;
    b = wq_addr.size(); dc = tx_done_cnt;
    err_at = rd_cnt + 1;
    start_tx(32'h1000, 16'd3);
    wait_idle("err_timeout", 100);
    chk("err_flag", {31'h0, tx_err}, 32'h1);
    chk("err_no_done", tx_done_cnt - dc, 0);
    chk("err_nwr", wq_addr.size() - b, 1);
    err_at = -1;
    b = wq_addr.size(); dc = tx_done_cnt;
    start_tx(32'h1000, 16'd1);
    chk("err_cleared", {30'h0, tx_err, tx_busy}, 32'h1);
    wait_idle("err2_timeout", 100);
    chk_wr("err2_b0", b, 32'h0, 32'hAA, 4'b0001);
    chk("err2_done_cnt", tx_done_cnt - dc, 1);

    // random back-pressure; same byte streams as zero-wait
    bp = 1; dma_tx_req = 1; dma_rx_req = 1;
    b = wq_addr.size();
    start_tx(32'h1002, 16'd3);
    wait_idle("bp_tx_timeout", 1000);
    chk_wr("bp_tx_b0", b,     32'h0, 32'hCC, 4'b0001);
    chk_wr("bp_tx_b1", b + 1, 32'h0, 32'hDD, 4'b0001);
    chk_wr("bp_tx_b2", b + 2, 32'h0, 32'h44, 4'b0001);
    rx_src.push_back(32'h5A); rx_src.push_back(32'hA5);
    b = wq_addr.size();
    start_rx(32'h2003, 16'd2);
    wait_idle("bp_rx_timeout", 1000);
    chk_wr("bp_rx_b0", b,     32'h2003, 32'h5A5A5A5A, 4'b1000);
    chk_wr("bp_rx_b1", b + 1, 32'h2004, 32'hA5A5A5A5, 4'b0001);
    chk("bp_stability", stab_viol, 0);
    bp = 0;

    // zero-length start
    rb = rd_cnt; b = wq_addr.size();
    start_tx(32'h1000, 16'd0);
    chk("zlen_done_n1", {30'h0, tx_done, tx_busy}, 32'h2);
    tick();
    chk("zlen_done_n2", {31'h0, tx_done}, 32'h0);
    repeat (5) tick();
    chk("zlen_no_reads", rd_cnt - rb, 0);
    chk("zlen_no_writes", wq_addr.size() - b, 0);

    // reset while the write phase is stalled
    hold_w = 1;
    start_tx(32'h1000, 16'd1);
    n = 0;
    while (!m_axi_awvalid && n < 20) begin tick(); n++; end
    chk("rstwr_reached", {30'h0, m_axi_awvalid, m_axi_wvalid}, 32'h3);
    rst = 1;
    tick();
    chk("rstwr_cleared", {28'h0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, tx_busy}, 32'h0);
    rst = 0; hold_w = 0;
    tick();
    b = wq_addr.size();
    start_tx(32'h1004, 16'd1);
    wait_idle("recover_timeout", 100);
    chk_wr("recover_b0", b, 32'h0, 32'h44, 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
